// File: rtl/student_ram_reader.sv
// Burst read engine for the 16-bit word RAM: issues sequential reads for a
// (base, length) command and streams the words out on a valid/ready port.
module student_ram_reader #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 16,
   parameter int RD_LAT    = 1,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + RD_LAT + 1);
   localparam int IDX_W = $clog2(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [LEN_W-1:0]  issue_cnt;
   logic [LEN_W-1:0]  accept_cnt;
   logic [RD_LAT-1:0] rd_pipe;
   logic [DATA_W-1:0] slot [BUF_DEPTH];
   logic [CNT_W-1:0]  occ;
   logic [CNT_W-1:0]  occ_nxt;
   logic [CNT_W-1:0]  in_flight;
   logic [CNT_W-1:0]  credit_used;
   logic [IDX_W-1:0]  wr_idx;
   logic              push;
   logic              pop;

   assign pop      = out_valid & out_ready;
   assign push     = rd_pipe[RD_LAT-1];
   assign mem_addr = addr_cnt;
   assign out_data = slot[0];

   // NOTE: combinational blocks use blocking '=' and give every output a
   // default on entry, so no path leaves a value held and no latch is inferred.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + CNT_W'(rd_pipe[i]);
      end
      // pop implies occ >= 1, so the subtraction cannot underflow
      credit_used = in_flight + occ - CNT_W'(pop);
      occ_nxt     = occ + CNT_W'(push) - CNT_W'(pop);
      wr_idx      = IDX_W'(occ - CNT_W'(pop));
   end

   // The read strobe credits the slot freed by this cycle's transfer, which is
   // what allows one word per cycle with only RD_LAT+1 buffer entries.
   assign mem_rd_en = (state == ISSUE) && (issue_cnt != '0) &&
                      (credit_used < CNT_W'(BUF_DEPTH));

   // NOTE: sequential blocks use non-blocking '<=' so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= mem_rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   // Shift-down buffer: slot 0 is the head, so out_data is a flop output.
   // NOTE: the buffer slots are reset even though they are storage, because
   // slot 0 drives out_data directly and must read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            slot[i] <= '0;
         end
         occ       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
               slot[i] <= slot[i+1];
            end
         end
         if (push) begin
            slot[wr_idx] <= mem_rdata;
         end
         occ       <= occ_nxt;
         out_valid <= (occ_nxt != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         addr_cnt   <= '0;
         issue_cnt  <= '0;
         accept_cnt <= '0;
      end else begin
         if (mem_rd_en) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            issue_cnt <= issue_cnt - LEN_W'(1);
         end
         if (pop) begin
            accept_cnt <= accept_cnt - LEN_W'(1);
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  addr_cnt   <= base_addr;
                  issue_cnt  <= length;
                  accept_cnt <= length;
                  busy       <= 1'b1;
                  // a zero-length burst still spends its capture cycle in
                  // DRAIN, so busy covers that cycle and the DONE pulse
                  state      <= (length == '0) ? DRAIN : ISSUE;
               end
            end
            ISSUE: begin
               if (mem_rd_en && issue_cnt == LEN_W'(1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (accept_cnt == '0 || (pop && accept_cnt == LEN_W'(1))) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_student_ram_reader.sv
// Directed bench for student_ram_reader: table of bursts against a RAM model
// holding RAM[i] = i ^ 16'hA5A5, plus start-hold and mid-burst reset sequences.
module tb_student_ram_reader;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 16;
   localparam int RD_LAT    = 1;
   localparam int BUF_DEPTH = 2;
   localparam int NV        = 5;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   student_ram_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-cycle-latency synchronous RAM
   initial mem_rdata = '0;
   always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [ADDR_W:0]   len;
      logic [5:0]        rmask;
      logic [DATA_W-1:0] exp_first;
      logic [DATA_W-1:0] exp_last;
      logic [ADDR_W-1:0] exp_first_addr;
      logic [ADDR_W-1:0] exp_last_addr;
      int                exp_lat;
      int                exp_busy;
      int                exp_gap;
   } vec_t;

   typedef struct {
      int                words;
      int                reads;
      int                dones;
      int                busy_cyc;
      int                lat;
      int                gap;
      int                order_err;
      int                addr_err;
      int                stall_err;
      int                max_out;
      int                done_nobusy;
      int                timeout;
      logic [DATA_W-1:0] first_word;
      logic [DATA_W-1:0] last_word;
      logic [ADDR_W-1:0] first_addr;
      logic [ADDR_W-1:0] last_addr;
   } res_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) ^ 16'hA5A5;
   endfunction

   // Issues one start, then observes cycle by cycle until the cycle after done.
   // Cycle 0 is the start cycle; inputs change at negedge, sampling is 1 unit later.
   task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                            input logic [5:0] rmask, input bit hold, output res_t r);
      int issued = 0;
      int popped = 0;
      int first_rd = 0;
      int first_vld = 0;
      int done_cyc = 0;
      int last_pop = 0;
      logic prev_stall = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      r = '{default: 0};
      r.timeout = 1;
      @(negedge clk);
      base_addr = b;
      length    = n;
      start     = 1'b1;
      out_ready = rmask[0];
      for (int cyc = 1; cyc < 200; cyc++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         out_ready = rmask[cyc % 6];
         #1;
         if (r.dones > 0 && !busy) begin
            r.timeout = 0;
            break;
         end
         if (issued - popped > r.max_out) r.max_out = issued - popped;
         if (busy) r.busy_cyc++;
         if (done) begin
            r.dones++;
            done_cyc = cyc;
            if (!busy) r.done_nobusy++;
         end
         if (prev_stall && (!out_valid || out_data !== prev_data)) r.stall_err++;
         if (mem_rd_en) begin
            if (issued == 0) begin
               first_rd = cyc;
               r.first_addr = mem_addr;
            end
            r.last_addr = mem_addr;
            if (mem_addr !== ADDR_W'(int'(b) + issued)) r.addr_err++;
            issued++;
         end
         if (out_valid && first_vld == 0) first_vld = cyc;
         if (out_valid && out_ready) begin
            if (popped == 0) r.first_word = out_data;
            r.last_word = out_data;
            if (out_data !== model_word(ADDR_W'(int'(b) + popped))) r.order_err++;
            popped++;
            last_pop = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
      r.words = popped;
      r.reads = issued;
      r.lat   = first_vld - first_rd;
      r.gap   = done_cyc - last_pop;
   endtask

   task automatic check_result(input string tag, input res_t r, input vec_t v);
      check({tag, " timeout"},     r.timeout, 0);
      check({tag, " words"},       r.words, 32'(v.len));
      check({tag, " reads"},       r.reads, 32'(v.len));
      check({tag, " dones"},       r.dones, 1);
      check({tag, " first_word"},  r.first_word, v.exp_first);
      check({tag, " last_word"},   r.last_word, v.exp_last);
      check({tag, " first_addr"},  r.first_addr, v.exp_first_addr);
      check({tag, " last_addr"},   r.last_addr, v.exp_last_addr);
      check({tag, " latency"},     r.lat, v.exp_lat);
      check({tag, " busy_cycles"}, r.busy_cyc, v.exp_busy);
      check({tag, " done_gap"},    r.gap, v.exp_gap);
      check({tag, " order_err"},   r.order_err, 0);
      check({tag, " addr_err"},    r.addr_err, 0);
      check({tag, " stall_err"},   r.stall_err, 0);
      check({tag, " credit_ok"},   32'(r.max_out <= BUF_DEPTH), 1);
      check({tag, " done_nobusy"}, r.done_nobusy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      int   n2;
      int   d2;
      int   popped;
      int   dn;
      logic [DATA_W-1:0] fw;
      vec_t post_rst;

      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i) ^ 16'hA5A5;

      //            base      len    rmask      first     last      faddr     laddr    lat busy gap
      vecs[0] = '{14'h0010, 15'd4, 6'b111111, 16'hA5B5, 16'hA5B6, 14'h0010, 14'h0013, 2, 7,  1};
      vecs[1] = '{14'h3FFE, 15'd4, 6'b111111, 16'h9A5B, 16'hA5A4, 14'h3FFE, 14'h0001, 2, 7,  1};
      vecs[2] = '{14'h0100, 15'd8, 6'b101001, 16'hA4A5, 16'hA4A2, 14'h0100, 14'h0107, 2, 18, 1};
      vecs[3] = '{14'h0200, 15'd0, 6'b111111, 16'h0000, 16'h0000, 14'h0000, 14'h0000, 0, 2,  2};
      vecs[4] = '{14'h0005, 15'd1, 6'b111111, 16'hA5A0, 16'hA5A0, 14'h0005, 14'h0005, 2, 4,  1};
      post_rst = '{14'h0030, 15'd3, 6'b111111, 16'hA595, 16'hA597, 14'h0030, 14'h0032, 2, 6, 1};

      start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset busy",      busy, 0);
      check("reset done",      done, 0);
      check("reset mem_rd_en", mem_rd_en, 0);
      check("reset mem_addr",  mem_addr, 0);
      check("reset out_valid", out_valid, 0);
      check("reset out_data",  out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < NV; v++) begin
         run_burst(vecs[v].base, vecs[v].len, vecs[v].rmask, 1'b0, r);
         check_result($sformatf("vec%0d", v), r, vecs[v]);
      end

      // start held high through a burst: ignored until the IDLE cycle after DONE
      run_burst(14'h0040, 15'd5, 6'b111111, 1'b1, r);
      check("hold timeout", r.timeout, 0);
      check("hold words",   r.words, 5);
      check("hold reads",   r.reads, 5);
      check("hold dones",   r.dones, 1);
      check("hold idle_gap_busy", busy, 0);
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      #1;
      check("hold restart_busy", busy, 1);
      n2 = 0; d2 = 0; fw = '0;
      for (int c = 0; c < 50; c++) begin
         if (out_valid && out_ready) begin
            if (n2 == 0) fw = out_data;
            n2++;
         end
         if (done) d2++;
         if (d2 > 0 && !busy) break;
         @(negedge clk);
         #1;
      end
      check("hold second_words", n2, 5);
      check("hold second_dones", d2, 1);
      check("hold second_first", fw, 16'hA5E5);

      // asynchronous reset after two of six words
      @(negedge clk);
      base_addr = 14'h0060; length = 15'd6; start = 1'b1; out_ready = 1'b1;
      popped = 0;
      for (int c = 0; c < 40 && popped < 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (out_valid && out_ready) popped++;
      end
      check("rst words_before", popped, 2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst busy",      busy, 0);
      check("rst done",      done, 0);
      check("rst mem_rd_en", mem_rd_en, 0);
      check("rst out_valid", out_valid, 0);
      check("rst out_data",  out_data, 0);
      check("rst mem_addr",  mem_addr, 0);
      dn = 0;
      repeat (2) begin
         @(negedge clk);
         #1;
         if (done || busy || out_valid) dn++;
      end
      check("rst held_quiet", dn, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_burst(post_rst.base, post_rst.len, post_rst.rmask, 1'b0, r);
      check_result("post_rst", r, post_rst);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
